// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction memory and IF/ID handshake bundle for ifetch_unit
interface ifetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - single-outstanding instruction fetch sequencer between PC register and imem
module ifetch_unit #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_en_o,
    input  logic            flush_i,
    ifetch_unit_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;

    logic            req_accept;
    logic            resp_take;

    // A grant only counts as a real fetch when no redirect lands in the same cycle.
    assign req_accept = (state_q == S_REQ) && bus.imem_gnt && !flush_i;
    assign resp_take  = (state_q == S_WAIT) && bus.imem_rvalid && !flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.imem_gnt) begin
                    state_d = flush_i ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = flush_i ? S_REQ : S_HOLD;
                end else if (flush_i) begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (bus.instr_ready || flush_i) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (bus.imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req  = 1'b0;
        bus.imem_addr = '0;
        pc_en_o       = 1'b0;
        if (state_q == S_REQ) begin
            bus.imem_req  = 1'b1;
            bus.imem_addr = pc_i;
            pc_en_o       = req_accept;
        end
    end

    always_comb begin
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        if (req_accept) begin
            addr_d = pc_i;
        end
        if (resp_take) begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = addr_q;
            instr_valid_d = 1'b1;
        end
        // Flush wins over acceptance; either one retires the held word.
        if ((state_q == S_HOLD) && (bus.instr_ready || flush_i)) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q        <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch sequencer between the PC register and instruction memory. It reads the current PC and issues one request at a time on a req/gnt/rvalid memory interface. It presents the returned word to the IF/ID stage over a valid/ready handshake and drives the PC register's advance enable. Pipeline flushes discard any in-flight or held fetch.

## Interface
- XLEN, 32, PC and address width
- ILEN, 32, instruction width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- pc  in  XLEN  current PC from PC register
- pc_en  out  1  PC register enable; 1 for exactly one cycle per accepted fetch
- flush  in  1  redirect/flush; PC register is loaded with the target by redirect logic the same cycle
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  ILEN  response data
- instr_valid  out  1  instr/instr_pc valid toward IF/ID
- instr_ready  in  1  IF/ID accepts this cycle
- instr  out  ILEN  fetched instruction
- instr_pc  out  XLEN  address instr was fetched from

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP.
- Registered state: `addr_q` (XLEN), `instr` (ILEN), `instr_pc` (XLEN), `instr_valid`.
- IDLE is the reset state. It moves to REQ unconditionally on the next edge.
- REQ:
  - imem_req=1 and imem_addr=pc, combinationally.
  - gnt && !flush: pc_en=1 and addr_q<=pc, then go to WAIT.
  - gnt && flush: pc_en=0 and the request is stale, so go to DROP.
  - !gnt: stay in REQ. imem_addr tracks pc, so after a flush it shows the redirect target.
- WAIT:
  - imem_req=0.
  - rvalid && !flush: instr<=imem_rdata, instr_pc<=addr_q, instr_valid<=1, go to HOLD.
  - flush with no rvalid: go to DROP.
  - flush && rvalid: discard data, go to REQ.
- HOLD:
  - instr_valid=1, and instr/instr_pc are stable.
  - instr_ready && !flush: instr_valid<=0, go to REQ.
  - flush, whether or not instr_ready is set: instr_valid<=0, go to REQ. A flush has priority over acceptance.
- DROP:
  - imem_req=0.
  - Wait for rvalid, discard the data, go to REQ.
  - A flush while in DROP stays in DROP.
- At most one outstanding memory transaction at any time.
- pc_en is asserted only in REQ on the gnt && !flush cycle. It is never asserted during a flush cycle.
- imem_addr is 0 whenever imem_req=0.

## Timing
- Reset (asynchronous): state=IDLE, instr_valid=0, instr=0, instr_pc=0, addr_q=0. Combinational outputs follow from IDLE: imem_req=0, imem_addr=0, pc_en=0.
- A reset in the middle of a transaction abandons it immediately. Memory responses arriving after reset and before the first new request are ignored.
- Memory contract: imem_rvalid arrives at earliest one cycle after gnt, and exactly once per grant. rvalid outside WAIT/DROP is ignored.
- Best-case latency: req+gnt in cycle t, rvalid in t+1, instr_valid=1 in t+2.
- If instr_ready is high in t+2, the next req is at t+3. Sustained throughput is therefore 1 instruction per 3 cycles.
- First request after reset deassertion is 2 cycles later (IDLE, then REQ).
- instr_valid, instr, and instr_pc are registered outputs. No combinational path exists from instr_ready to imem_req.

## Test plan
- **Basic fetch:** reset, pc=0x100, gnt=1 on the first req, rvalid next cycle with rdata=0x00500093, ready=1.
  - Required: pc_en pulses once.
  - Required: instr=0x00500093 and instr_pc=0x100, valid 2 cycles after the grant.
  - Required: the next req follows 1 cycle later.
- **Backpressure:** instr_ready=0 for 5 cycles in HOLD.
  - Required: instr_valid stays 1 and instr/instr_pc stay constant.
  - Required: imem_req=0 and pc_en=0 throughout.
  - Required: the next req comes the cycle after ready=1.
- **Grant delay and flush during REQ:** gnt=0 for 3 cycles; pc changes 0x200→0x400 with flush in cycle 2; gnt in cycle 3.
  - Required: imem_addr=0x400 at the grant.
  - Required: instr_pc=0x400.
- **Flush in WAIT:**
  - Required: the response (rdata=0xDEADBEEF) arrives 2 cycles later and is discarded, with instr_valid never set.
  - Required: a new req with the redirected pc follows the cycle after that rvalid.
- **Flush with gnt, and flush with ready:**
  - flush+gnt in REQ. Required: pc_en=0, state goes to DROP.
  - flush+ready in HOLD. Required: instr_valid drops, no double acceptance.
- **Asynchronous reset mid-WAIT:**
  - Required: all outputs are 0 immediately.
  - Required: a late rvalid is ignored.
  - Required: the first req is 2 cycles after reset release.
